// File: rtl/rr_arbiter4_5_pkg.sv
// Shared CPU-peripheral constants: arbiter FSM encoding, hold default and bus widths.
package rr_arbiter4_5_pkg;

    localparam int unsigned NREQ             = 4;
    localparam int unsigned IDXW             = 2;
    localparam int unsigned ADDRW            = 5;
    localparam int unsigned MAX_HOLD_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux4x5.sv
// 5-bit 4:1 select mux with an enable that forces the output to zero.
module mux4x5
    import rr_arbiter4_5_pkg::*;
(
    input  logic [IDXW-1:0]  sel,
    input  logic             en,
    input  logic [ADDRW-1:0] d0,
    input  logic [ADDRW-1:0] d1,
    input  logic [ADDRW-1:0] d2,
    input  logic [ADDRW-1:0] d3,
    output logic [ADDRW-1:0] y_c
);

    always_comb begin
        y_c = '0;
        if (en) begin
            unique case (sel)
                2'd0:    y_c = d0;
                2'd1:    y_c = d1;
                2'd2:    y_c = d2;
                default: y_c = d3;
            endcase
        end
    end

endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority pick: requester at ptr first, then ptr+1..ptr+3 with mod-4 wrap.
module rr_pick4
    import rr_arbiter4_5_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] onehot_c,
    output logic [IDXW-1:0] idx_c,
    output logic            any_c
);

    logic [IDXW-1:0] cand;

    // Scan lowest priority first so the highest-priority requester is written last.
    always_comb begin
        idx_c = '0;
        cand  = '0;
        any_c = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + IDXW'(k);
            if (req[cand]) begin
                idx_c = cand;
            end
        end
        onehot_c = any_c ? (NREQ'(1) << idx_c) : '0;
    end

endmodule

// File: rtl/rr_arbiter4_5.sv
// Four-way round-robin arbiter with per-owner hold limit and zero-bubble handoff.
module rr_arbiter4_5
    import rr_arbiter4_5_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [ADDRW-1:0] addr0,
    input  logic [ADDRW-1:0] addr1,
    input  logic [ADDRW-1:0] addr2,
    input  logic [ADDRW-1:0] addr3,
    output logic [NREQ-1:0]  gnt,
    output logic [IDXW-1:0]  sel,
    output logic [ADDRW-1:0] o,
    output logic             valid
);

    localparam int unsigned HW = $clog2(MAX_HOLD) + 1;

    arb_state_t      state, state_n;
    logic [IDXW-1:0] ptr, ptr_n;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic [NREQ-1:0] gnt_n;
    logic [IDXW-1:0] sel_n;
    logic            valid_n;

    logic [IDXW-1:0] pick_ptr_c;
    logic [NREQ-1:0] pick_onehot_c;
    logic [IDXW-1:0] pick_idx_c;
    logic            pick_any_c;

    // While owned, arbitration looks from the slot after the owner, so the owner ranks last.
    assign pick_ptr_c = (state == GRANT) ? sel + IDXW'(1) : ptr;

    rr_pick4 u_pick (
        .req      (req),
        .ptr      (pick_ptr_c),
        .onehot_c (pick_onehot_c),
        .idx_c    (pick_idx_c),
        .any_c    (pick_any_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            sel      <= '0;
            valid    <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            gnt      <= gnt_n;
            sel      <= sel_n;
            valid    <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        gnt_n   = gnt;
        sel_n   = sel;
        valid_n = valid;
        unique case (state)
            IDLE: begin
                if (pick_any_c) begin
                    state_n = GRANT;
                    gnt_n   = pick_onehot_c;
                    sel_n   = pick_idx_c;
                    valid_n = 1'b1;
                    hold_n  = '0;
                end
            end
            GRANT: begin
                if (req[sel] && (hold_cnt < HW'(MAX_HOLD - 1))) begin
                    hold_n = hold_cnt + HW'(1);
                end else begin
                    // Release or timeout: advance pointer and re-arbitrate in the same edge.
                    ptr_n  = pick_ptr_c;
                    hold_n = '0;
                    if (pick_any_c) begin
                        gnt_n   = pick_onehot_c;
                        sel_n   = pick_idx_c;
                        valid_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        valid_n = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    mux4x5 u_mux (
        .sel (sel),
        .en  (valid),
        .d0  (addr0),
        .d1  (addr1),
        .d2  (addr2),
        .d3  (addr3),
        .y_c (o)
    );

endmodule

// File: tb/tb_rr_arbiter4_5.sv
// Directed bench for rr_arbiter4_5 with per-cycle grant/mux invariants.
module tb_rr_arbiter4_5;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [4:0] addr0, addr1, addr2, addr3;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [4:0] o;
    logic       valid;

    logic [4:0] exp_addr [4];
    int         n_checks;
    int         n_pass;

    rr_arbiter4_5 #(.MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .addr0 (addr0),
        .addr1 (addr1),
        .addr2 (addr2),
        .addr3 (addr3),
        .gnt   (gnt),
        .sel   (sel),
        .o     (o),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one edge, then check the invariants that hold in every cycle.
    task automatic tick();
        logic [4:0] exp_o;
        @(posedge clk);
        #1;
        exp_o = valid ? exp_addr[sel] : 5'd0;
        chk("onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("valid_eq_or_gnt", 32'(valid), 32'(|gnt));
        chk("gnt_sel_eq_valid", 32'(gnt[sel]), 32'(valid));
        chk("o_mux", 32'(o), 32'(exp_o));
    endtask

    task automatic expect_grant(input string tag, input int idx);
        logic [3:0] eg;
        eg = 4'(1) << idx;
        chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
        chk({tag, "_sel"}, 32'(sel), 32'(idx));
        chk({tag, "_o"}, 32'(o), 32'(exp_addr[idx]));
    endtask

    task automatic expect_idle(input string tag, input int exp_sel);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_sel"}, 32'(sel), 32'(exp_sel));
        chk({tag, "_o"}, 32'(o), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_addr[0] = 5'h03;
        exp_addr[1] = 5'h0A;
        exp_addr[2] = 5'h15;
        exp_addr[3] = 5'h1C;
        addr0 = 5'h03;
        addr1 = 5'h0A;
        addr2 = 5'h15;
        addr3 = 5'h1C;
        rst_n = 1'b0;
        req   = 4'b1111;

        // Reset state, even with requests pending.
        tick();
        tick();
        expect_idle("reset", 0);
        chk("reset_ptr", 32'(dut.ptr), 32'd0);

        // All requesting: each owner holds 8 cycles in order 0,1,2,3,0.
        rst_n = 1'b1;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                expect_grant("rr_all", g % 4);
            end
        end

        // Drop everything: back to idle, sel keeps last owner, ptr moves past it.
        req = 4'b0000;
        tick();
        expect_idle("rr_all_release", 0);
        chk("rr_all_release_ptr", 32'(dut.ptr), 32'd1);

        // Single requester 2 for three cycles then release.
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_grant("single2", 2);
        end
        req = 4'b0000;
        tick();
        expect_idle("single2_release", 2);
        tick();
        expect_idle("single2_idle_hold", 2);

        // Owner 1 drops while 3 requests in the same cycle: no bubble.
        req = 4'b0010;
        tick();
        expect_grant("handoff_own1", 1);
        req = 4'b1000;
        tick();
        expect_grant("handoff_to3", 3);
        req = 4'b0000;
        tick();
        expect_idle("handoff_release", 3);

        // Lone requester 2 held 20 cycles: continuous grant, counter wraps at timeout.
        req = 4'b0100;
        for (int i = 1; i <= 20; i++) begin
            tick();
            expect_grant("timeout_self", 2);
            chk("timeout_self_hold_bound", 32'(dut.hold_cnt <= 7), 32'd1);
            if (i == 8)  chk("timeout_hold_max", 32'(dut.hold_cnt), 32'd7);
            if (i == 9) begin
                chk("timeout_wrap1", 32'(dut.hold_cnt), 32'd0);
                chk("timeout_ptr", 32'(dut.ptr), 32'd3);
            end
            if (i == 17) chk("timeout_wrap2", 32'(dut.hold_cnt), 32'd0);
            if (i == 20) chk("timeout_hold_end", 32'(dut.hold_cnt), 32'd3);
        end
        req = 4'b0000;
        tick();
        expect_idle("timeout_release", 2);
        chk("timeout_release_ptr", 32'(dut.ptr), 32'd3);

        // ptr=3 with req 1 and 2: order 3,0,1,2 picks 1; its timeout hands to 2.
        req = 4'b0110;
        for (int c = 0; c < 8; c++) begin
            tick();
            expect_grant("timeout_hand_own1", 1);
        end
        tick();
        expect_grant("timeout_hand_to2", 2);

        // Owner 2 drops while 1 and 3 request: ptr=3 picks 3.
        req = 4'b1010;
        tick();
        expect_grant("pre_reset_to3", 3);

        // Reset mid-grant drops the grant; afterwards ptr=0 picks 1 from 1010.
        rst_n = 1'b0;
        tick();
        expect_idle("mid_reset", 0);
        chk("mid_reset_ptr", 32'(dut.ptr), 32'd0);
        rst_n = 1'b1;
        tick();
        expect_grant("post_reset", 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4_5.md
RR_ARBITER4_5 -- requirements
Module: rr_arbiter4_5

Interface
REQ-001 The parameter list SHALL contain: MAX_HOLD, default 8, maximum consecutive cycles one requester may own the grant (legal 1..16).
REQ-002 Port list (one clock; reset is synchronous and active-low) SHALL be:
  clk     input   1   rising-edge clock
  rst_n   input   1   synchronous active-low reset
  req     input   4   request per requester, level, held while resource needed
  addr0   input   5   requester 0 register index
  addr1   input   5   requester 1 register index
  addr2   input   5   requester 2 register index
  addr3   input   5   requester 3 register index
  gnt     output  4   one-hot grant, registered
  sel     output  2   index of current/last owner, registered; drives the shared 5-bit 4:1 select mux
  o       output  5   granted register index; addr[sel] when valid, else 5'b00000
  valid   output  1   high while any grant is active (equals |gnt)

Function
REQ-003 The FSM SHALL have two states: IDLE (no owner) and GRANT (one owner, index = sel).
REQ-004 The block SHALL hold a 2-bit round-robin pointer ptr; the requester at ptr has highest priority, then ptr+1, ptr+2, ptr+3 (mod 4 wrap).
REQ-005 In IDLE, at an edge where req != 0, the block SHALL grant the highest-priority requesting index, enter GRANT, set sel, and set hold_cnt=0; latency req-to-gnt is one cycle.
REQ-006 In IDLE with req == 0, all outputs SHALL hold (gnt=0, valid=0, sel unchanged).
REQ-007 In GRANT, the block SHALL keep the owner while req[sel]=1 and hold_cnt < MAX_HOLD-1, incrementing hold_cnt each cycle.
REQ-008 Release: at an edge where req[sel]=0, ptr SHALL become sel+1 and the next owner SHALL be chosen from req under the new ptr in the same edge (zero-bubble handoff); if no request is pending, the FSM SHALL return to IDLE with gnt=0.
REQ-009 Timeout: at an edge where req[sel]=1 and hold_cnt = MAX_HOLD-1, ptr SHALL become sel+1 and arbitration SHALL proceed as in REQ-008; the timed-out owner is eligible only at lowest priority and SHALL be re-granted (hold_cnt=0) only if no other requester is pending.
REQ-010 gnt SHALL be one-hot or zero in every cycle; gnt[sel]=valid.
REQ-011 o SHALL be combinational from sel, valid and addr0..addr3, with no added latency.
REQ-012 Requests arriving in the same cycle as a release SHALL be considered in that release's arbitration.
REQ-013 hold_cnt SHALL be ceil(log2(MAX_HOLD))+1 bits wide; it SHALL never exceed MAX_HOLD-1.

Reset
REQ-014 When rst_n=0 at a rising edge, the block SHALL set state=IDLE, ptr=0, hold_cnt=0, gnt=4'b0000, sel=2'b00, valid=0, o=5'b00000, regardless of req or any grant in progress.
REQ-015 The first arbitration after reset SHALL give requester 0 highest priority.
REQ-016 Reset asserted during GRANT SHALL drop gnt on that edge; no handoff SHALL occur.

Structure
REQ-017 The FSM state encoding (IDLE=1'b0, GRANT=1'b1) and the MAX_HOLD default SHALL reside in the shared CPU-peripheral constants package.
REQ-018 The combinational priority pick (req, ptr -> one-hot + index + any) SHALL be a sub-module named rr_pick4; the owner, pointer and counter registers SHALL stay in rr_arbiter4_5.
REQ-019 o SHALL be produced by the team's existing 5-bit 4:1 select mux, driven by sel and gated by valid.

Verification
REQ-020 Reset then req=4'b1111 held -> gnt 0001, 0010, 0100, 1000, 0001 each lasting 8 cycles (MAX_HOLD=8); o follows addr0..addr3.
REQ-021 req=4'b0100 for 3 cycles then 0 -> gnt=0100 for cycles 1..3, sel=2, o=addr2, then gnt=0, valid=0, sel stays 2.
REQ-022 Owner 1 drops req while req[3]=1 in the same cycle -> next cycle gnt=1000, no idle bubble.
REQ-023 Only req[2]=1 held 20 cycles, MAX_HOLD=8 -> gnt=0100 continuous, hold_cnt wraps 7->0 twice, ptr=3 after the first timeout.
REQ-024 rst_n=0 mid-grant with req=4'b1010 -> next cycle gnt=0, sel=0; after rst_n=1, requester 1 is granted first (ptr=0 priority order 0,1,2,3).
REQ-025 A checker SHALL assert on every cycle that gnt is one-hot or zero and that o=addr[sel] when valid, else 0.
